// File: rtl/err_report_pkg.sv
// Shared types and constants for the error/frequency report serializer.
// State encoding is visible on state_dbg, so values are pinned explicitly.
package err_report_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FREQ_HDR   = 4'd1,
        ST_FREQ_CHUNK = 4'd2,
        ST_DONE_F     = 4'd3,
        ST_ERR_HDR    = 4'd4,
        ST_CH_ID      = 4'd5,
        ST_ADDR_CHUNK = 4'd6,
        ST_CNT_BYTE   = 4'd7,
        ST_RESUME     = 4'd8
    } state_e;

    localparam logic [7:0] FREQ_HDR_BYTE = 8'h7F;
    localparam logic [7:0] ERR_HDR_BYTE  = 8'h40;
    localparam logic [1:0] CH_PFX        = 2'b10;
    localparam logic [1:0] FREQ_PFX      = 2'b11;
    localparam logic [1:0] DATA_PFX      = 2'b00;

    function automatic int ceil_div6(input int width);
        return (width + 5) / 6;
    endfunction

endpackage

// File: rtl/err_latch_bank.sv
// Per-channel sticky error latch with first-address capture.
// Build option ERR_COUNT_EN adds 6-bit saturating per-channel error counters.
module err_latch_bank #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sense_en,
    input  logic                     capture_en,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        err,
    input  logic [NUM_CH*ADDR_W-1:0] err_addr,
`ifdef ERR_COUNT_EN
    input  logic [NUM_CH-1:0]        cnt_clear,
    output logic [NUM_CH*6-1:0]      cnt,
`endif
    output logic [NUM_CH-1:0]        latched,
    output logic [NUM_CH*ADDR_W-1:0] addr
);

    // NOTE: captured addresses keep their value when the flags clear; they are only
    // rewritten in IDLE, so the serializer can read them for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latched <= '0;
            addr    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!sense_en || clear) begin
                    latched[c] <= 1'b0;
                end else if (capture_en && err[c] && !latched[c]) begin
                    latched[c]                  <= 1'b1;
                    addr[c*ADDR_W +: ADDR_W]    <= err_addr[c*ADDR_W +: ADDR_W];
                end
            end
        end
    end

`ifdef ERR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!sense_en || cnt_clear[c]) begin
                    cnt[c*6 +: 6] <= '0;
                end else if (err[c] && cnt[c*6 +: 6] != 6'h3F) begin
                    cnt[c*6 +: 6] <= cnt[c*6 +: 6] + 6'd1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/err_report_serializer.sv
// Frames latched RAM-checker errors and frequency codes into paced 6-bit UART bytes.
// Build option ERR_COUNT_EN appends a per-channel error count byte after each address.
module err_report_serializer
    import err_report_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 10,
    parameter int FREQ_W         = 9,
    parameter int GAP_CYCLES     = 10000,
    parameter int RESUME_TIMEOUT = 1048575
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     sense_en,
    input  logic [NUM_CH-1:0]        err,
    input  logic [NUM_CH*ADDR_W-1:0] err_addr,
    input  logic                     freq_req,
    input  logic [FREQ_W-1:0]        frequency,
    output logic                     freq_done,
    output logic [7:0]               uart_data,
    output logic                     uart_valid,
    output logic                     pause,
    output logic [3:0]               state_dbg
);

    localparam int NCH   = ceil_div6(ADDR_W);
    localparam int NFQ   = ceil_div6(FREQ_W);
    localparam int MAXC  = (NCH > NFQ) ? NCH : NFQ;
    localparam int CHK_W = $clog2(MAXC + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES);
    localparam int RES_W = $clog2(RESUME_TIMEOUT + 1);

    state_e                   state;
    logic [GAP_W-1:0]         gap_cnt;
    logic [RES_W-1:0]         res_cnt;
    logic [CHK_W-1:0]         chunk;
    logic [NUM_CH-1:0]        pending;
    logic [NUM_CH-1:0]        pend_oh;
    logic [NUM_CH-1:0]        latched;
    logic [NUM_CH*ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0]        resume_addr;
    logic [ADDR_W-1:0]        pend_addr;
    logic [ADDR_W-1:0]        latch_addr;
    logic [5:0]               pend_id;
    logic [NFQ*6-1:0]         freq_sh;
    logic [NCH*6-1:0]         addr_sh;
    logic                     byte_state;
    logic                     gap_done;
    logic                     last_addr_chunk;
    logic                     addr_match;

`ifdef ERR_COUNT_EN
    logic [5:0]          ch;
    logic [NUM_CH-1:0]   cnt_clear;
    logic [NUM_CH*6-1:0] cnt;
    logic [5:0]          cnt_sel;
    logic                send_cnt;
`endif

    err_latch_bank #(
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W)
    ) u_latch_bank (
        .clk       (CLOCK_50),
        .rst       (reset),
        .sense_en  (sense_en),
        .capture_en(state == ST_IDLE && sense_en),
        .clear     (state == ST_RESUME),
        .err       (err),
        .err_addr  (err_addr),
`ifdef ERR_COUNT_EN
        .cnt_clear (cnt_clear),
        .cnt       (cnt),
`endif
        .latched   (latched),
        .addr      (addr_q)
    );

    assign byte_state = (state == ST_FREQ_HDR) || (state == ST_FREQ_CHUNK) ||
                        (state == ST_ERR_HDR)  || (state == ST_CH_ID) ||
                        (state == ST_ADDR_CHUNK) || (state == ST_CNT_BYTE);
    assign gap_done        = byte_state && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign last_addr_chunk = (chunk == CHK_W'(NCH - 1));
    assign pend_oh         = pending & (~pending + NUM_CH'(1));
    assign state_dbg       = state;

    // Descending scan so the lowest-index set channel wins.
    always_comb begin
        pend_id    = '0;
        pend_addr  = '0;
        latch_addr = '0;
        addr_match = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c]) begin
                pend_id   = 6'(c);
                pend_addr = addr_q[c*ADDR_W +: ADDR_W];
            end
            if (latched[c]) latch_addr = addr_q[c*ADDR_W +: ADDR_W];
            if (err_addr[c*ADDR_W +: ADDR_W] == resume_addr) addr_match = 1'b1;
        end
    end

`ifdef ERR_COUNT_EN
    assign send_cnt = gap_done && (state == ST_ADDR_CHUNK) && last_addr_chunk;

    always_comb begin
        cnt_sel   = '0;
        cnt_clear = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 6'(c)) begin
                cnt_sel      = cnt[c*6 +: 6];
                cnt_clear[c] = send_cnt;
            end
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            uart_data   <= '0;
            uart_valid  <= 1'b0;
            freq_done   <= 1'b0;
            pause       <= 1'b0;
            gap_cnt     <= '0;
            res_cnt     <= '0;
            chunk       <= '0;
            pending     <= '0;
            resume_addr <= '0;
            freq_sh     <= '0;
            addr_sh     <= '0;
`ifdef ERR_COUNT_EN
            ch          <= '0;
`endif
        end else begin
            uart_valid <= 1'b0;
            freq_done  <= 1'b0;
            gap_cnt    <= (byte_state && !gap_done) ? gap_cnt + GAP_W'(1) : '0;

            case (state)
                ST_IDLE: begin
                    chunk   <= '0;
                    res_cnt <= '0;
                    if (freq_req) begin
                        state      <= ST_FREQ_HDR;
                        pause      <= 1'b1;
                        uart_valid <= 1'b1;
                        uart_data  <= FREQ_HDR_BYTE;
                        freq_sh    <= (NFQ*6)'(frequency);
                    end else if ((|latched) && sense_en) begin
                        state       <= ST_ERR_HDR;
                        pause       <= 1'b1;
                        uart_valid  <= 1'b1;
                        uart_data   <= ERR_HDR_BYTE;
                        pending     <= latched;
                        resume_addr <= latch_addr;
                    end
                end

                ST_FREQ_HDR, ST_FREQ_CHUNK: if (gap_done) begin
                    if (state == ST_FREQ_CHUNK && chunk == CHK_W'(NFQ - 1)) begin
                        state     <= ST_DONE_F;
                        freq_done <= 1'b1;
                    end else begin
                        state      <= ST_FREQ_CHUNK;
                        uart_valid <= 1'b1;
                        uart_data  <= {FREQ_PFX, freq_sh[5:0]};
                        freq_sh    <= freq_sh >> 6;
                        if (state == ST_FREQ_CHUNK) chunk <= chunk + CHK_W'(1);
                    end
                end

                ST_DONE_F: begin
                    state <= ST_IDLE;
                    pause <= 1'b0;
                end

                ST_ERR_HDR, ST_CH_ID, ST_ADDR_CHUNK, ST_CNT_BYTE: if (gap_done) begin
                    if (state == ST_CH_ID || (state == ST_ADDR_CHUNK && !last_addr_chunk)) begin
                        state      <= ST_ADDR_CHUNK;
                        uart_valid <= 1'b1;
                        uart_data  <= {DATA_PFX, addr_sh[5:0]};
                        addr_sh    <= addr_sh >> 6;
                        chunk      <= (state == ST_CH_ID) ? '0 : chunk + CHK_W'(1);
                    end
`ifdef ERR_COUNT_EN
                    else if (state == ST_ADDR_CHUNK) begin
                        state      <= ST_CNT_BYTE;
                        uart_valid <= 1'b1;
                        uart_data  <= {DATA_PFX, cnt_sel};
                    end
`endif
                    else if (|pending) begin
                        state      <= ST_CH_ID;
                        uart_valid <= 1'b1;
                        uart_data  <= {CH_PFX, pend_id};
                        pending    <= pending & ~pend_oh;
                        addr_sh    <= (NCH*6)'(pend_addr);
`ifdef ERR_COUNT_EN
                        ch         <= pend_id;
`endif
                    end else begin
                        state <= ST_RESUME;
                    end
                end

                ST_RESUME: begin
                    if (addr_match || res_cnt == RES_W'(RESUME_TIMEOUT - 1)) begin
                        state   <= ST_IDLE;
                        pause   <= 1'b0;
                        res_cnt <= '0;
                    end else begin
                        res_cnt <= res_cnt + RES_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    pause <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_err_report_serializer.sv
// Directed bench for err_report_serializer: error frames, frequency frame,
// resume match/timeout and mid-frame reset, with hand-computed byte streams.
module tb_err_report_serializer;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 10;
    localparam int FREQ_W = 9;
    localparam int GAP    = 16;
    localparam int TMO    = 100;
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RESUME = 4'd8;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     sense_en = 1'b0;
    logic [NUM_CH-1:0]        err = '0;
    logic [NUM_CH*ADDR_W-1:0] err_addr = '0;
    logic                     freq_req = 1'b0;
    logic [FREQ_W-1:0]        frequency = '0;
    logic                     freq_done;
    logic [7:0]               uart_data;
    logic                     uart_valid;
    logic                     pause;
    logic [3:0]               state_dbg;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         t0;
    logic [7:0] got_q[$];
    int         got_t[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    err_report_serializer #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .FREQ_W(FREQ_W),
        .GAP_CYCLES(GAP), .RESUME_TIMEOUT(TMO)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .sense_en  (sense_en),
        .err       (err),
        .err_addr  (err_addr),
        .freq_req  (freq_req),
        .frequency (frequency),
        .freq_done (freq_done),
        .uart_data (uart_data),
        .uart_valid(uart_valid),
        .pause     (pause),
        .state_dbg (state_dbg)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_valid === 1'b1) begin
            got_q.push_back(uart_data);
            got_t.push_back(cyc);
        end
        if (freq_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, got_q.size(), n);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
        int k = 0;
        while (state_dbg !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, state_dbg, s);
    endtask

    // Compares the captured stream with exp_q; gap before byte index skip is not checked.
    task automatic check_frame(input string tag, input int skip);
        wait_bytes({tag, "_count"}, exp_q.size(), 2000);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
                if (i > 0 && i != skip)
                    check($sformatf("%s_gap%0d", tag, i), got_t[i] - got_t[i-1], GAP);
            end
        end
    endtask

    task automatic new_test();
        err      = '0;
        freq_req = 1'b0;
        sense_en = 1'b0;
        @(negedge clk);
        sense_en = 1'b1;
        @(negedge clk);
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", uart_valid, 1'b0);
        check("rst_data", uart_data, 8'h00);
        check("rst_done", freq_done, 1'b0);
        check("rst_pause", pause, 1'b0);
        check("rst_state", state_dbg, S_IDLE);
        reset = 1'b0;

        // single error on channel 1, ignored strobe on channel 0 mid-frame
        new_test();
        err_addr = {10'h2A5, 10'h000};
        err      = 2'b10;
        @(negedge clk);
        err      = '0;
        err_addr = '0;
        exp_q    = '{8'h40, 8'h81, 8'h25, 8'h0A};
`ifdef ERR_COUNT_EN
        exp_q.push_back(8'h01);
`endif
        repeat (20) @(negedge clk);
        check("t1_pause_mid", pause, 1'b1);
        err_addr = {10'h000, 10'h3C3};
        err      = 2'b01;
        @(negedge clk);
        err      = '0;
        err_addr = '0;
        check_frame("t1", -1);
        wait_state("t1_resume", S_RESUME, 100);
        repeat (10) @(negedge clk);
        check("t1_hold", state_dbg, S_RESUME);
        check("t1_pause_res", pause, 1'b1);
        err_addr = {10'h2A5, 10'h000};
        @(negedge clk);
        check("t1_exit", state_dbg, S_IDLE);
        check("t1_pause_off", pause, 1'b0);
        err_addr = '0;
        repeat (40) @(negedge clk);
        check("t1_no_stray", got_q.size(), exp_q.size());

        // both channels in the same cycle, resume on channel 0 address
        new_test();
        err_addr = {10'h3FF, 10'h001};
        err      = 2'b11;
        @(negedge clk);
        err      = '0;
        err_addr = {10'h2AA, 10'h155};
`ifdef ERR_COUNT_EN
        exp_q = '{8'h40, 8'h80, 8'h01, 8'h00, 8'h01, 8'h81, 8'h3F, 8'h0F, 8'h01};
`else
        exp_q = '{8'h40, 8'h80, 8'h01, 8'h00, 8'h81, 8'h3F, 8'h0F};
`endif
        check_frame("t2", -1);
        wait_state("t2_resume", S_RESUME, 100);
        err_addr = {10'h3FF, 10'h155};
        repeat (3) @(negedge clk);
        check("t2_ch1_addr_no_exit", state_dbg, S_RESUME);
        err_addr = {10'h2AA, 10'h001};
        @(negedge clk);
        check("t2_exit", state_dbg, S_IDLE);

        // frequency frame wins over a pending error, then resume timeout
        new_test();
        frequency = 9'h1A3;
        err_addr  = {10'h000, 10'h123};
        err       = 2'b01;
        freq_req  = 1'b1;
        @(negedge clk);
        err       = '0;
        freq_req  = 1'b0;
        err_addr  = '0;
        exp_q     = '{8'h7F, 8'hE3, 8'hC6, 8'h40, 8'h80, 8'h23, 8'h04};
`ifdef ERR_COUNT_EN
        exp_q.push_back(8'h01);
`endif
        check_frame("t3", 3);
        check("t3_done_pulses", done_cnt, 1);
        wait_state("t3_resume", S_RESUME, 100);
        t0 = cyc;
        wait_state("t3_timeout_idle", S_IDLE, 300);
        check("t3_timeout_len", cyc - t0, TMO);
        check("t3_pause_off", pause, 1'b0);

        // reset during the third byte of an error frame
        new_test();
        err_addr = {10'h2A5, 10'h000};
        err      = 2'b10;
        @(negedge clk);
        err      = '0;
        err_addr = '0;
        wait_bytes("t4_three", 3, 200);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t4_valid", uart_valid, 1'b0);
        check("t4_data", uart_data, 8'h00);
        check("t4_pause", pause, 1'b0);
        check("t4_state", state_dbg, S_IDLE);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        check("t4_no_more", got_q.size(), 3);

`ifdef ERR_COUNT_EN
        // 70 strobes on channel 0 saturate the count byte at 0x3F
        new_test();
        frequency = '0;
        err_addr  = {10'h000, 10'h2C1};
        freq_req  = 1'b1;
        err       = 2'b01;
        @(negedge clk);
        freq_req  = 1'b0;
        repeat (69) @(negedge clk);
        err       = '0;
        exp_q     = '{8'h7F, 8'hC0, 8'hC0, 8'h40, 8'h80, 8'h01, 8'h0B, 8'h3F};
        check_frame("t6", 3);
        wait_state("t6_idle", S_IDLE, 300);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
